// File: rtl/mmio_gpio_cr_if.sv
// Opcode type and request/response bus for the mmio_gpio_cr control-register block.
package mmio_gpio_cr_pkg;
  typedef enum logic [1:0] {RD = 2'd0, WR = 2'd1, RD_RSP = 2'd2} t_opcode;
endpackage

interface mmio_gpio_cr_if;
  import mmio_gpio_cr_pkg::*;
  logic        F2C_ReqValidQ502H;
  t_opcode     F2C_ReqOpcodeQ502H;
  logic [31:0] F2C_ReqAddressQ502H;
  logic [31:0] F2C_ReqDataQ502H;
  logic        F2C_RspValidQ500H;
  t_opcode     F2C_RspOpcodeQ500H;
  logic [31:0] F2C_RspAddressQ500H;
  logic [31:0] F2C_RspDataQ500H;

  modport master (
    output F2C_ReqValidQ502H, F2C_ReqOpcodeQ502H, F2C_ReqAddressQ502H, F2C_ReqDataQ502H,
    input  F2C_RspValidQ500H, F2C_RspOpcodeQ500H, F2C_RspAddressQ500H, F2C_RspDataQ500H
  );
  modport slave (
    input  F2C_ReqValidQ502H, F2C_ReqOpcodeQ502H, F2C_ReqAddressQ502H, F2C_ReqDataQ502H,
    output F2C_RspValidQ500H, F2C_RspOpcodeQ500H, F2C_RspAddressQ500H, F2C_RspDataQ500H
  );
endinterface

// File: rtl/mmio_gpio_cr.sv
// GPIO control-register block: RW output regs, synchronised inputs, W1C rising-edge sticky bits.
// Define MMIO_GPIO_CR_IRQ_EN to add IRQ_MASK at 0x300 and a registered level Irq.

// One input channel: 2-flop synchroniser, edge detect and sticky bits (set beats clear).
module mmio_gpio_cr_in_lane #(
  parameter int W = 16
) (
  input  logic         gclk,
  input  logic         grst_n,
  input  logic [W-1:0] pin,
  input  logic [W-1:0] clr,
  output logic [W-1:0] sync,
  output logic [W-1:0] sticky
);
  logic [W-1:0] meta_q, prev_q;
  logic         armed_q;

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      meta_q  <= '0;
      sync    <= '0;
      prev_q  <= '0;
      sticky  <= '0;
      armed_q <= 1'b0;
    end else begin
      meta_q  <= pin;
      sync    <= meta_q;
      prev_q  <= sync;
      armed_q <= 1'b1;
      // Edge detection is held off on the first cycle out of reset.
      sticky  <= (sticky & ~clr) | (armed_q ? (sync & ~prev_q) : '0);
    end
  end
endmodule

module mmio_gpio_cr
  import mmio_gpio_cr_pkg::*;
#(
  parameter int          NUM_OUT    = 7,
  parameter int          OUT_W      = 8,
  parameter int          NUM_IN     = 4,
  parameter int          IN_W       = 16,
  parameter int          MSB_REGION = 31,
  parameter int          LSB_REGION = 12,
  parameter logic [31:0] CR_REGION  = 32'h0004_0000
) (
  input  logic                     QClk,
  input  logic                     RstQnnnL,
  mmio_gpio_cr_if.slave            bus,
  output logic [NUM_OUT*OUT_W-1:0] OutPins,
  input  logic [NUM_IN*IN_W-1:0]   InPins,
  output logic                     Irq
);
  localparam int STAGES = 2;

  typedef struct packed {
    t_opcode     op;
    logic [31:0] addr;
    logic [31:0] data;
  } req_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } rsp_t;

  logic [STAGES:0]               vld_pipe;
  req_t                          s1;
  rsp_t                          s2, s3;
  logic                          acc, mapped, wr_en;
  logic [1:0]                    grp;
  logic [5:0]                    idx;
  logic [31:0]                   rdata;
  logic [NUM_OUT-1:0][OUT_W-1:0] out_q, out_pins_q;
  logic [NUM_IN-1:0][IN_W-1:0]   in_sync, sticky_q, sticky_clr;
  logic                          unused_s1;

  assign acc = bus.F2C_ReqValidQ502H &&
               (bus.F2C_ReqAddressQ502H[MSB_REGION:LSB_REGION] == CR_REGION[MSB_REGION-LSB_REGION:0]);

  // Decode happens in stage 1: offset[9:8] selects the bank, offset[7:2] the index.
  assign grp       = s1.addr[9:8];
  assign idx       = s1.addr[7:2];
  assign mapped    = (s1.addr[11:10] == 2'b00) && (s1.addr[1:0] == 2'b00);
  assign wr_en     = vld_pipe[0] && (s1.op == WR) && mapped;
  assign unused_s1 = ^{s1.addr[31:12], s1.data};

  always_ff @(posedge QClk or negedge RstQnnnL) begin
    if (!RstQnnnL) begin
      vld_pipe <= '0;
      s1       <= '0;
      s2       <= '0;
      s3       <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:0], acc};
      if (acc)
        s1 <= '{op: bus.F2C_ReqOpcodeQ502H, addr: bus.F2C_ReqAddressQ502H, data: bus.F2C_ReqDataQ502H};
      s2 <= '{addr: s1.addr, data: rdata};
      s3 <= s2;
    end
  end

  always_ff @(posedge QClk or negedge RstQnnnL) begin
    if (!RstQnnnL) begin
      out_q      <= '0;
      out_pins_q <= '0;
    end else begin
      for (int i = 0; i < NUM_OUT; i++)
        if (wr_en && grp == 2'd0 && idx == 6'(i)) out_q[i] <= s1.data[OUT_W-1:0];
      out_pins_q <= out_q;
    end
  end

  always_comb begin
    sticky_clr = '0;
    for (int j = 0; j < NUM_IN; j++)
      if (wr_en && grp == 2'd2 && idx == 6'(j)) sticky_clr[j] = s1.data[IN_W-1:0];
  end

  for (genvar j = 0; j < NUM_IN; j++) begin : g_in
    mmio_gpio_cr_in_lane #(.W(IN_W)) u_lane (
      .gclk   (QClk),
      .grst_n (RstQnnnL),
      .pin    (InPins[j*IN_W +: IN_W]),
      .clr    (sticky_clr[j]),
      .sync   (in_sync[j]),
      .sticky (sticky_q[j])
    );
  end

`ifdef MMIO_GPIO_CR_IRQ_EN
  logic [NUM_IN-1:0] irq_mask_q, irq_src;
  logic              irq_q;

  always_comb begin
    irq_src = '0;
    for (int j = 0; j < NUM_IN; j++) irq_src[j] = (|sticky_q[j]) & irq_mask_q[j];
  end

  always_ff @(posedge QClk or negedge RstQnnnL) begin
    if (!RstQnnnL) begin
      irq_mask_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      if (wr_en && grp == 2'd3 && idx == 6'd0) irq_mask_q <= s1.data[NUM_IN-1:0];
      irq_q <= |irq_src;
    end
  end

  assign Irq = irq_q;
`else
  assign Irq = 1'b0;
`endif

  // Sticky reads sample the register before this cycle's set lands.
  always_comb begin
    rdata = '0;
    if (s1.op != WR && mapped) begin
      case (grp)
        2'd0: for (int i = 0; i < NUM_OUT; i++) if (idx == 6'(i)) rdata = 32'(out_q[i]);
        2'd1: for (int j = 0; j < NUM_IN; j++)  if (idx == 6'(j)) rdata = 32'(in_sync[j]);
        2'd2: for (int j = 0; j < NUM_IN; j++)  if (idx == 6'(j)) rdata = 32'(sticky_q[j]);
`ifdef MMIO_GPIO_CR_IRQ_EN
        2'd3: if (idx == 6'd0) rdata = 32'(irq_mask_q);
`endif
        default: ;
      endcase
    end
  end

  assign bus.F2C_RspValidQ500H   = vld_pipe[STAGES];
  assign bus.F2C_RspOpcodeQ500H  = RD_RSP;
  assign bus.F2C_RspAddressQ500H = s3.addr;
  assign bus.F2C_RspDataQ500H    = s3.data;
  assign OutPins                 = out_pins_q;
endmodule

// File: tb/tb_mmio_gpio_cr.sv
// Self-checking bench for mmio_gpio_cr: scoreboard queue of expected responses plus direct pin checks.
`timescale 1ns/1ps
module tb_mmio_gpio_cr;
  import mmio_gpio_cr_pkg::*;

  localparam int          NUM_OUT = 7;
  localparam int          OUT_W   = 8;
  localparam int          NUM_IN  = 4;
  localparam int          IN_W    = 16;
  localparam logic [31:0] BASE    = 32'h4000_0000;

  logic                     QClk = 1'b0;
  logic                     RstQnnnL = 1'b0;
  logic [NUM_OUT*OUT_W-1:0] OutPins;
  logic [NUM_IN*IN_W-1:0]   InPins;
  logic                     Irq;
  int                       cyc = 0;
  int                       errors = 0;
  int                       checks = 0;

  typedef struct {
    int          cyc;
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;
  exp_t exp_q[$];

  mmio_gpio_cr_if bus();

  mmio_gpio_cr #(.NUM_OUT(NUM_OUT), .OUT_W(OUT_W), .NUM_IN(NUM_IN), .IN_W(IN_W)) dut (
    .QClk     (QClk),
    .RstQnnnL (RstQnnnL),
    .bus      (bus),
    .OutPins  (OutPins),
    .InPins   (InPins),
    .Irq      (Irq)
  );

  always #5 QClk = ~QClk;
  always @(posedge QClk) cyc <= cyc + 1;

  // Response monitor: every response must match the head of the queue, cycle included.
  always @(negedge QClk) begin
    if (bus.F2C_RspValidQ500H === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_rsp: got addr=%h data=%h at cyc %0d, want no response",
                 bus.F2C_RspAddressQ500H, bus.F2C_RspDataQ500H, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (cyc != e.cyc || bus.F2C_RspAddressQ500H !== e.addr ||
            bus.F2C_RspDataQ500H !== e.data || bus.F2C_RspOpcodeQ500H !== RD_RSP) begin
          errors++;
          $display("FAIL rsp: got cyc=%0d addr=%h data=%h op=%0d, want cyc=%0d addr=%h data=%h op=%0d",
                   cyc, bus.F2C_RspAddressQ500H, bus.F2C_RspDataQ500H, bus.F2C_RspOpcodeQ500H,
                   e.cyc, e.addr, e.data, RD_RSP);
        end
      end
    end
  end

  task automatic req(input t_opcode op, input logic [31:0] addr, input logic [31:0] data,
                     input bit exp_rsp, input logic [31:0] exp_data);
    exp_t e;
    @(negedge QClk);
    bus.F2C_ReqValidQ502H   = 1'b1;
    bus.F2C_ReqOpcodeQ502H  = op;
    bus.F2C_ReqAddressQ502H = addr;
    bus.F2C_ReqDataQ502H    = data;
    if (exp_rsp) begin
      e.cyc  = cyc + 3;
      e.addr = addr;
      e.data = exp_data;
      exp_q.push_back(e);
    end
  endtask

  task automatic idle();
    @(negedge QClk);
    bus.F2C_ReqValidQ502H = 1'b0;
  endtask

  task automatic drain();
    idle();
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge QClk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d responses outstanding, want 0", exp_q.size());
      exp_q.delete();
    end
    repeat (4) @(negedge QClk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge QClk);
    checks++;
    if (bus.F2C_RspValidQ500H !== 1'b0 || bus.F2C_RspAddressQ500H !== 32'h0 ||
        bus.F2C_RspDataQ500H !== 32'h0) begin
      errors++;
      $display("FAIL reset_rsp: got vld=%b addr=%h data=%h, want 0", bus.F2C_RspValidQ500H,
               bus.F2C_RspAddressQ500H, bus.F2C_RspDataQ500H);
    end
    checks++;
    if (OutPins !== '0 || Irq !== 1'b0) begin
      errors++;
      $display("FAIL reset_pins: got out=%h irq=%b, want 0", OutPins, Irq);
    end
    RstQnnnL = 1'b1;
    repeat (2) @(negedge QClk);
  endtask

  task automatic test_out_regs();
    logic [NUM_OUT*OUT_W-1:0] exp_pins;
    req(WR, BASE + 32'h000, 32'h0000_01A5, 1, 32'h0);
    idle();
    @(negedge QClk);
    checks++;
    if (OutPins[7:0] !== 8'h00) begin
      errors++;
      $display("FAIL out_pins_early: got %h want 00", OutPins[7:0]);
    end
    @(negedge QClk);
    checks++;
    if (OutPins[7:0] !== 8'hA5) begin
      errors++;
      $display("FAIL out_pins_n3: got %h want a5", OutPins[7:0]);
    end
    req(RD, BASE + 32'h000, 32'h0, 1, 32'h0000_00A5);
    req(WR, BASE + 32'h018, 32'hFFFF_FF5A, 1, 32'h0);
    req(RD, BASE + 32'h018, 32'h0, 1, 32'h0000_005A);
    req(WR, BASE + 32'h01C, 32'h0000_0011, 1, 32'h0);
    req(RD, BASE + 32'h01C, 32'h0, 1, 32'h0);
    drain();
    exp_pins = '0;
    exp_pins[0 +: OUT_W] = 8'hA5;
    exp_pins[6*OUT_W +: OUT_W] = 8'h5A;
    checks++;
    if (OutPins !== exp_pins) begin
      errors++;
      $display("FAIL out_pins_all: got %h want %h", OutPins, exp_pins);
    end
  endtask

  task automatic test_wr_rd_b2b();
    req(WR, BASE + 32'h008, 32'h0000_0033, 1, 32'h0);
    req(RD, BASE + 32'h008, 32'h0, 1, 32'h0000_0033);
    req(WR, BASE + 32'h008, 32'h0000_0044, 1, 32'h0);
    req(RD, BASE + 32'h008, 32'h0, 1, 32'h0000_0044);
    drain();
  endtask

  task automatic test_in_sync();
    @(negedge QClk);
    InPins[0*IN_W +: IN_W] = 16'h1234;
    InPins[1*IN_W +: IN_W] = 16'h0003;
    repeat (2) @(negedge QClk);
    req(RD, BASE + 32'h104, 32'h0, 1, 32'h3);
    req(RD, BASE + 32'h100, 32'h0, 1, 32'h1234);
    req(RD, BASE + 32'h204, 32'h0, 1, 32'h3);
    req(WR, BASE + 32'h104, 32'hFFFF, 1, 32'h0);
    req(RD, BASE + 32'h104, 32'h0, 1, 32'h3);
    req(RD, BASE + 32'h110, 32'h0, 1, 32'h0);
    req(RD, BASE + 32'h200, 32'h0, 1, 32'h1234);
    drain();
  endtask

  task automatic test_sticky_w1c();
    @(negedge QClk);
    InPins[1*IN_W +: IN_W] = 16'h0000;
    repeat (3) @(negedge QClk);
    req(WR, BASE + 32'h204, 32'h1, 1, 32'h0);
    req(RD, BASE + 32'h204, 32'h0, 1, 32'h2);
    idle();
    // New edge on bit0 lands in the same cycle as the W1C of bit0.
    InPins[1*IN_W] = 1'b1;
    req(WR, BASE + 32'h204, 32'h1, 1, 32'h0);
    req(RD, BASE + 32'h204, 32'h0, 1, 32'h3);
    req(WR, BASE + 32'h204, 32'hFFFF, 1, 32'h0);
    req(RD, BASE + 32'h204, 32'h0, 1, 32'h0);
    drain();
  endtask

  task automatic test_back_to_back();
    req(RD, BASE + 32'h000, 32'h0, 1, 32'h0000_00A5);
    req(RD, BASE + 32'h100, 32'h0, 1, 32'h0000_1234);
    req(RD, BASE + 32'h3FC, 32'h0, 1, 32'h0);
    req(RD, 32'h5000_0000, 32'h0, 0, 32'h0);
    drain();
  endtask

  task automatic test_irq();
`ifdef MMIO_GPIO_CR_IRQ_EN
    req(WR, BASE + 32'h204, 32'hFFFF, 1, 32'h0);
    req(WR, BASE + 32'h300, 32'h2, 1, 32'h0);
    req(RD, BASE + 32'h300, 32'h0, 1, 32'h2);
    drain();
    checks++;
    if (Irq !== 1'b0) begin
      errors++;
      $display("FAIL irq_idle: got %b want 0", Irq);
    end
    @(negedge QClk);
    InPins[1*IN_W + 2] = 1'b1;
    repeat (5) @(negedge QClk);
    checks++;
    if (Irq !== 1'b1) begin
      errors++;
      $display("FAIL irq_set: got %b want 1", Irq);
    end
    req(WR, BASE + 32'h204, 32'hFFFF, 1, 32'h0);
    idle();
    @(negedge QClk);
    checks++;
    if (Irq !== 1'b1) begin
      errors++;
      $display("FAIL irq_hold: got %b want 1", Irq);
    end
    @(negedge QClk);
    checks++;
    if (Irq !== 1'b0) begin
      errors++;
      $display("FAIL irq_clear: got %b want 0", Irq);
    end
    drain();
`else
    @(negedge QClk);
    InPins[1*IN_W + 2] = 1'b1;
    repeat (5) @(negedge QClk);
    checks++;
    if (Irq !== 1'b0) begin
      errors++;
      $display("FAIL irq_tied: got %b want 0", Irq);
    end
    req(WR, BASE + 32'h300, 32'hF, 1, 32'h0);
    req(RD, BASE + 32'h300, 32'h0, 1, 32'h0);
    drain();
    checks++;
    if (Irq !== 1'b0) begin
      errors++;
      $display("FAIL irq_tied_after_wr: got %b want 0", Irq);
    end
`endif
  endtask

  task automatic test_reset_inflight();
    @(negedge QClk);
    InPins = '0;
    repeat (4) @(negedge QClk);
    req(WR, BASE + 32'h000, 32'h77, 0, 32'h0);
    req(RD, BASE + 32'h000, 32'h0, 0, 32'h0);
    @(negedge QClk);
    bus.F2C_ReqValidQ502H = 1'b0;
    RstQnnnL = 1'b0;
    repeat (2) @(negedge QClk);
    checks++;
    if (bus.F2C_RspValidQ500H !== 1'b0 || OutPins !== '0 || Irq !== 1'b0) begin
      errors++;
      $display("FAIL inflight_in_reset: got vld=%b out=%h irq=%b, want 0", bus.F2C_RspValidQ500H, OutPins, Irq);
    end
    RstQnnnL = 1'b1;
    repeat (8) @(negedge QClk);
    checks++;
    if (bus.F2C_RspAddressQ500H !== 32'h0 || bus.F2C_RspDataQ500H !== 32'h0 ||
        OutPins !== '0 || Irq !== 1'b0) begin
      errors++;
      $display("FAIL inflight_after: got addr=%h data=%h out=%h irq=%b, want 0",
               bus.F2C_RspAddressQ500H, bus.F2C_RspDataQ500H, OutPins, Irq);
    end
    req(RD, BASE + 32'h000, 32'h0, 1, 32'h0);
    req(RD, BASE + 32'h204, 32'h0, 1, 32'h0);
    req(RD, BASE + 32'h104, 32'h0, 1, 32'h0);
    drain();
  endtask

  initial begin
    bus.F2C_ReqValidQ502H   = 1'b0;
    bus.F2C_ReqOpcodeQ502H  = RD;
    bus.F2C_ReqAddressQ502H = 32'h0;
    bus.F2C_ReqDataQ502H    = 32'h0;
    InPins                  = '0;
    test_reset();
    test_out_regs();
    test_wr_rd_b2b();
    test_in_sync();
    test_sticky_w1c();
    test_back_to_back();
    test_irq();
    test_reset_inflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule
